// File: rtl/mem_pkg.sv
// Constants and FSM state type shared by the cache controller and the main-memory back end.
package mem_pkg;

   localparam int unsigned OFFSET_W = 6;
   localparam int unsigned INDEX_W  = 7;
   localparam int unsigned TAG_W    = 19;
   localparam int unsigned DATA_W   = 64;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StRespond
   } mm_state_e;

endpackage

// File: rtl/mm_wb_buffer.sv
// One-entry posted write buffer: holds a write-back, drains it to the array over LATENCY cycles
// and exposes the entry for read forwarding.
module mm_wb_buffer #(
   parameter int unsigned IDX_W   = 10,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned LATENCY = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic              full_o,
   output logic              hit_o,
   output logic [DATA_W-1:0] fwd_data_o,
   output logic              drain_we_o,
   output logic [IDX_W-1:0]  drain_idx_o,
   output logic [DATA_W-1:0] drain_data_o
);

   localparam logic [7:0] LatLoad = 8'(LATENCY - 1);

   logic              valid_q, valid_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [7:0]        cnt_q, cnt_d;

   always_comb begin
      valid_d    = valid_q;
      idx_d      = idx_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      drain_we_o = 1'b0;
      if (valid_q) begin
         if (cnt_q == 8'd0) begin
            drain_we_o = 1'b1;
            valid_d    = 1'b0;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end else if (wr_en_i) begin
         valid_d = 1'b1;
         idx_d   = wr_idx_i;
         data_d  = wr_data_i;
         cnt_d   = LatLoad;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign full_o       = valid_q;
   assign hit_o        = valid_q && (idx_q == rd_idx_i);
   assign fwd_data_o   = data_q;
   assign drain_idx_o  = idx_q;
   assign drain_data_o = data_q;

endmodule

// File: rtl/mm_backend.sv
// Fixed-latency main-memory model answering cache refills and write-backs with an MM_ready pulse.
// Define MM_WB_BUFFER_EN to add a one-entry posted write buffer with read forwarding.
module mm_backend #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = mem_pkg::DATA_W,
   parameter int unsigned MEM_DEPTH = 1024,
   parameter int unsigned LATENCY   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              MM_ready,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   import mem_pkg::*;

   localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
   localparam logic [7:0]  LatLoad = 8'(LATENCY - 1);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   mm_state_e         state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              op_wr_q, op_wr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [IDX_W-1:0]  req_idx;
   logic              acc_we, hold;
   logic              arr_we;
   logic [IDX_W-1:0]  arr_widx;
   logic [DATA_W-1:0] arr_wdata;
   logic              unused_addr;

   // Upper address bits alias onto the same word; the block offset is ignored.
   assign req_idx     = mem_addr[OFFSET_W +: IDX_W];
   assign unused_addr = ^{mem_addr[ADDR_W-1:OFFSET_W+IDX_W], mem_addr[OFFSET_W-1:0]};

`ifdef MM_WB_BUFFER_EN
   logic              buf_wr, buf_full, buf_hit, drain_we;
   logic [IDX_W-1:0]  drain_idx;
   logic [DATA_W-1:0] drain_data, buf_fwd;

   mm_wb_buffer #(
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W),
      .LATENCY(LATENCY)
   ) u_wb_buffer (
      .clk_i       (clk),
      .rst_ni      (rst),
      .wr_en_i     (buf_wr),
      .wr_idx_i    (req_idx),
      .wr_data_i   (mem_wdata),
      .rd_idx_i    (req_idx),
      .full_o      (buf_full),
      .hit_o       (buf_hit),
      .fwd_data_o  (buf_fwd),
      .drain_we_o  (drain_we),
      .drain_idx_o (drain_idx),
      .drain_data_o(drain_data)
   );

   // Single-ported array: a missing read waits for the drain before counting.
   assign hold      = buf_full;
   assign arr_we    = drain_we;
   assign arr_widx  = drain_idx;
   assign arr_wdata = drain_data;
   assign busy      = (state_q != StIdle) || buf_full;
`else
   assign hold      = 1'b0;
   assign arr_we    = acc_we;
   assign arr_widx  = idx_q;
   assign arr_wdata = wdata_q;
   assign busy      = (state_q != StIdle);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      acc_we  = 1'b0;
`ifdef MM_WB_BUFFER_EN
      buf_wr  = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
`ifdef MM_WB_BUFFER_EN
            if (mem_write) begin
               if (!buf_full) begin
                  buf_wr  = 1'b1;
                  state_d = StRespond;
               end
            end else if (mem_read) begin
               op_wr_d = 1'b0;
               idx_d   = req_idx;
               if (buf_hit) begin
                  rdata_d = buf_fwd;
                  state_d = StRespond;
               end else begin
                  cnt_d   = LatLoad;
                  state_d = StAccess;
               end
            end
`else
            // Write wins a tie; the held read is taken after the write's MM_ready.
            if (mem_write || mem_read) begin
               op_wr_d = mem_write;
               idx_d   = req_idx;
               wdata_d = mem_wdata;
               cnt_d   = LatLoad;
               state_d = StAccess;
            end
`endif
         end
         StAccess: begin
            if (!hold) begin
               if (cnt_q == 8'd0) begin
                  state_d = StRespond;
                  if (op_wr_q) begin
                     acc_we = 1'b1;
                  end else begin
                     rdata_d = mem[idx_q];
                  end
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         StRespond: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (arr_we) begin
         mem[arr_widx] <= arr_wdata;
      end
   end

   assign MM_ready  = (state_q == StRespond);
   assign mem_rdata = rdata_q;

endmodule
